// File: rtl/cdb_result_arbiter.sv
// Shares the common data bus between NUM_UNITS execute stages with a round-robin
// pick, registering the winner's result toward the ROB/RS broadcast.
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | CDB register holds nothing; any requester may be granted
// FULL  | CDB register holds a word; refill only when ROB drains it
module cdb_result_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int UNITLOG    = $clog2(NUM_UNITS)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            flush_i,
    input  logic [NUM_UNITS-1:0]            unitValid_i,
    input  logic [NUM_UNITS*ROBsizeLog-1:0] unitTag_i,
    input  logic [NUM_UNITS*64-1:0]         unitVal_i,
    input  logic [NUM_UNITS*4-1:0]          unitFlags_i,
    output logic [NUM_UNITS-1:0]            canGo_o,
    input  logic                            cdbReady_i,
    output logic                            cdbValid_o,
    output logic [ROBsizeLog-1:0]           cdbTag_o,
    output logic [63:0]                     cdbVal_o,
    output logic [3:0]                      cdbFlags_o,
    output logic [UNITLOG-1:0]              cdbUnit_o
);

    localparam int IW = UNITLOG + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [UNITLOG-1:0]      rr_ptr;
    logic [UNITLOG-1:0]      win;
    logic                    any_req;
    logic                    load;
    logic                    grant;
    logic [ROBsizeLog-1:0]   sel_tag;
    logic [63:0]             sel_val;
    logic [3:0]              sel_flags;

    // Round-robin scan starting at rr_ptr; the wide index never overflows since
    // rr_ptr + offset stays below 2*NUM_UNITS.
    always_comb begin
        logic [IW-1:0] idx;
        win     = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = {1'b0, rr_ptr} + IW'(i);
            if (idx >= IW'(NUM_UNITS)) begin
                idx = idx - IW'(NUM_UNITS);
            end
            if (!any_req && unitValid_i[idx[UNITLOG-1:0]]) begin
                win     = idx[UNITLOG-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        sel_tag   = '0;
        sel_val   = '0;
        sel_flags = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (win == UNITLOG'(k)) begin
                sel_tag   = unitTag_i[k*ROBsizeLog +: ROBsizeLog];
                sel_val   = unitVal_i[k*64 +: 64];
                sel_flags = unitFlags_i[k*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (grant) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (flush_i || (cdbReady_i && !grant)) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Reset and flush both gate load, so the grant can never fire under either.
    always_comb begin
        load     = reset_i && !flush_i && ((state == EMPTY) || cdbReady_i);
        grant    = load && any_req;
        canGo_o  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            canGo_o[k] = grant && (win == UNITLOG'(k));
        end
    end

    assign cdbValid_o = (state == FULL);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rr_ptr     <= '0;
            cdbTag_o   <= '0;
            cdbVal_o   <= '0;
            cdbFlags_o <= '0;
            cdbUnit_o  <= '0;
        end else if (grant) begin
            rr_ptr     <= (win == UNITLOG'(NUM_UNITS - 1)) ? '0 : win + UNITLOG'(1);
            cdbTag_o   <= sel_tag;
            cdbVal_o   <= sel_val;
            cdbFlags_o <= sel_flags;
            cdbUnit_o  <= win;
        end
    end

endmodule

// File: tb/tb_cdb_result_arbiter.sv
// Bench for cdb_result_arbiter: directed scenarios plus a randomized run against a
// queue-free behavioural model of the round-robin CDB.
module tb_cdb_result_arbiter;

    localparam int NU = 4;
    localparam int TW = 6;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              flush_i;
    logic [NU-1:0]     unitValid_i;
    logic [NU*TW-1:0]  unitTag_i;
    logic [NU*64-1:0]  unitVal_i;
    logic [NU*4-1:0]   unitFlags_i;
    logic [NU-1:0]     canGo_o;
    logic              cdbReady_i;
    logic              cdbValid_o;
    logic [TW-1:0]     cdbTag_o;
    logic [63:0]       cdbVal_o;
    logic [3:0]        cdbFlags_o;
    logic [1:0]        cdbUnit_o;

    int checks = 0;
    int errors = 0;

    cdb_result_arbiter #(.NUM_UNITS(NU), .ROBsize(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .unitValid_i (unitValid_i),
        .unitTag_i   (unitTag_i),
        .unitVal_i   (unitVal_i),
        .unitFlags_i (unitFlags_i),
        .canGo_o     (canGo_o),
        .cdbReady_i  (cdbReady_i),
        .cdbValid_o  (cdbValid_o),
        .cdbTag_o    (cdbTag_o),
        .cdbVal_o    (cdbVal_o),
        .cdbFlags_o  (cdbFlags_o),
        .cdbUnit_o   (cdbUnit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0; flush_i = 1'b0; cdbReady_i = 1'b1;
        unitValid_i = 4'hF; unitTag_i = '0; unitVal_i = '0; unitFlags_i = '0;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            #2;
            checks++;
            if (canGo_o !== 4'b0000) begin
                errors++; $display("FAIL reset_cango: got %b want 0000", canGo_o);
            end
            checks++;
            if (cdbValid_o !== 1'b0 || cdbTag_o !== '0 || cdbUnit_o !== 2'd0) begin
                errors++;
                $display("FAIL reset_cdb: valid %b tag %0d unit %0d want 0/0/0", cdbValid_o, cdbTag_o, cdbUnit_o);
            end
        end
        reset_i = 1'b1;
        #2;
        checks++;
        if (canGo_o !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant: got %b want 0001", canGo_o);
        end
        next_cycle();
        checks++;
        if (cdbValid_o !== 1'b1 || cdbUnit_o !== 2'd0) begin
            errors++; $display("FAIL reset_first_word: valid %b unit %0d want 1/0", cdbValid_o, cdbUnit_o);
        end
    endtask

    task automatic test_single();
        unitValid_i = 4'b0100;
        unitTag_i[2*TW +: TW] = 6'd5;
        unitVal_i[2*64 +: 64] = 64'h1234;
        unitFlags_i[2*4 +: 4] = 4'hA;
        cdbReady_i = 1'b1;
        #2;
        checks++;
        if (canGo_o !== 4'b0100) begin
            errors++; $display("FAIL single_cango: got %b want 0100", canGo_o);
        end
        next_cycle();
        unitValid_i = 4'b0000;
        checks++;
        if (cdbValid_o !== 1'b1 || cdbTag_o !== 6'd5 || cdbVal_o !== 64'h1234 ||
            cdbFlags_o !== 4'hA || cdbUnit_o !== 2'd2) begin
            errors++;
            $display("FAIL single_word: valid %b tag %0d val %h flags %h unit %0d want 1/5/1234/a/2",
                     cdbValid_o, cdbTag_o, cdbVal_o, cdbFlags_o, cdbUnit_o);
        end
    endtask

    task automatic test_fairness();
        reset_i = 1'b0;
        next_cycle();
        reset_i = 1'b1;
        cdbReady_i = 1'b1;
        unitValid_i = 4'hF;
        for (int k = 0; k < NU; k++) unitTag_i[k*TW +: TW] = TW'(10 + k);
        for (int i = 0; i < 6; i++) begin
            #2;
            checks++;
            if (canGo_o !== 4'(1 << (i % 4))) begin
                errors++; $display("FAIL fair_cango[%0d]: got %b want %b", i, canGo_o, 4'(1 << (i % 4)));
            end
            next_cycle();
            checks++;
            if (cdbValid_o !== 1'b1 || cdbUnit_o !== 2'(i % 4) || cdbTag_o !== TW'(10 + i % 4)) begin
                errors++;
                $display("FAIL fair_word[%0d]: valid %b unit %0d tag %0d want 1/%0d/%0d",
                         i, cdbValid_o, cdbUnit_o, cdbTag_o, i % 4, 10 + i % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        unitValid_i = 4'b0010;
        unitTag_i[1*TW +: TW] = 6'd33;
        unitVal_i[1*64 +: 64] = 64'hBEEF;
        cdbReady_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (canGo_o !== 4'b0000 || cdbValid_o !== 1'b1 || cdbTag_o !== 6'd11 || cdbUnit_o !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: cango %b valid %b tag %0d unit %0d want 0000/1/11/1",
                         c, canGo_o, cdbValid_o, cdbTag_o, cdbUnit_o);
            end
            next_cycle();
        end
        cdbReady_i = 1'b1;
        #2;
        checks++;
        if (canGo_o !== 4'b0010) begin
            errors++; $display("FAIL bp_release: got %b want 0010", canGo_o);
        end
        next_cycle();
        unitValid_i = 4'b0000;
        checks++;
        if (cdbValid_o !== 1'b1 || cdbTag_o !== 6'd33 || cdbVal_o !== 64'hBEEF || cdbUnit_o !== 2'd1) begin
            errors++;
            $display("FAIL bp_word: valid %b tag %0d val %h unit %0d want 1/33/beef/1",
                     cdbValid_o, cdbTag_o, cdbVal_o, cdbUnit_o);
        end
    endtask

    task automatic test_wrap();
        unitValid_i = 4'b0100;
        #2;
        checks++;
        if (canGo_o !== 4'b0100) begin
            errors++; $display("FAIL wrap_pre: got %b want 0100", canGo_o);
        end
        next_cycle();
        unitValid_i = 4'b0011;
        #2;
        checks++;
        if (canGo_o !== 4'b0001) begin
            errors++; $display("FAIL wrap_grant: got %b want 0001", canGo_o);
        end
        next_cycle();
        unitValid_i = 4'b1010;
        #2;
        checks++;
        if (canGo_o !== 4'b0010) begin
            errors++; $display("FAIL wrap_ptr: got %b want 0010", canGo_o);
        end
        next_cycle();
        unitValid_i = 4'b0000;
    endtask

    task automatic test_flush();
        unitValid_i = 4'b1000;
        flush_i = 1'b1;
        cdbReady_i = 1'b0;
        #2;
        checks++;
        if (canGo_o !== 4'b0000) begin
            errors++; $display("FAIL flush_cango: got %b want 0000", canGo_o);
        end
        next_cycle();
        flush_i = 1'b0;
        cdbReady_i = 1'b1;
        unitValid_i = 4'b0110;
        checks++;
        if (cdbValid_o !== 1'b0) begin
            errors++; $display("FAIL flush_valid: got %b want 0", cdbValid_o);
        end
        #2;
        checks++;
        if (canGo_o !== 4'b0100) begin
            errors++; $display("FAIL flush_ptr: got %b want 0100", canGo_o);
        end
        next_cycle();
        flush_i = 1'b1;
        reset_i = 1'b0;
        unitValid_i = 4'hF;
        #2;
        checks++;
        if (canGo_o !== 4'b0000) begin
            errors++; $display("FAIL flushrst_cango: got %b want 0000", canGo_o);
        end
        next_cycle();
        checks++;
        if (cdbValid_o !== 1'b0 || cdbTag_o !== '0 || cdbVal_o !== '0 || cdbFlags_o !== '0 || cdbUnit_o !== 2'd0) begin
            errors++;
            $display("FAIL flushrst_cdb: valid %b tag %0d val %h flags %h unit %0d want all 0",
                     cdbValid_o, cdbTag_o, cdbVal_o, cdbFlags_o, cdbUnit_o);
        end
        reset_i = 1'b1;
        flush_i = 1'b0;
        #2;
        checks++;
        if (canGo_o !== 4'b0001) begin
            errors++; $display("FAIL flushrst_grant: got %b want 0001", canGo_o);
        end
        next_cycle();
        unitValid_i = 4'b0000;
    endtask

    task automatic test_random();
        bit          u_v   [NU];
        logic [TW-1:0] u_tag [NU];
        logic [63:0] u_val [NU];
        logic [3:0]  u_fl  [NU];
        int          m_rr;
        bit          m_full;
        logic [TW-1:0] m_tag;
        logic [63:0] m_val;
        logic [3:0]  m_fl;
        int          m_unit;
        bit          ld;
        int          w;
        logic [NU-1:0] exp_cg;

        reset_i = 1'b0; flush_i = 1'b0; unitValid_i = '0;
        next_cycle();
        m_rr = 0; m_full = 0; m_tag = '0; m_val = '0; m_fl = '0; m_unit = 0;
        for (int k = 0; k < NU; k++) begin
            u_v[k] = 0; u_tag[k] = '0; u_val[k] = '0; u_fl[k] = '0;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset_i    = ($urandom_range(0, 63) != 0);
            flush_i    = ($urandom_range(0, 15) == 0);
            cdbReady_i = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NU; k++) begin
                if (!u_v[k] && $urandom_range(0, 1) == 1) begin
                    u_v[k]   = 1;
                    u_tag[k] = TW'($urandom_range(0, 32));
                    u_val[k] = {$urandom, $urandom};
                    u_fl[k]  = 4'($urandom);
                end
                unitValid_i[k]          = u_v[k];
                unitTag_i[k*TW +: TW]   = u_tag[k];
                unitVal_i[k*64 +: 64]   = u_val[k];
                unitFlags_i[k*4 +: 4]   = u_fl[k];
            end
            #2;

            ld = reset_i && !flush_i && (!m_full || cdbReady_i);
            w = -1;
            for (int i = 0; i < NU; i++) begin
                int k;
                k = (m_rr + i) % NU;
                if (w < 0 && u_v[k]) w = k;
            end
            exp_cg = (ld && w >= 0) ? NU'(1 << w) : '0;

            checks++;
            if (canGo_o !== exp_cg) begin
                errors++; $display("FAIL rand_cango[%0d]: got %b want %b", cyc, canGo_o, exp_cg);
            end
            checks++;
            if (cdbValid_o !== m_full) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b want %b", cyc, cdbValid_o, m_full);
            end
            if (m_full) begin
                checks++;
                if (cdbTag_o !== m_tag || cdbVal_o !== m_val || cdbFlags_o !== m_fl || cdbUnit_o !== 2'(m_unit)) begin
                    errors++;
                    $display("FAIL rand_word[%0d]: tag %0d val %h flags %h unit %0d want %0d/%h/%h/%0d",
                             cyc, cdbTag_o, cdbVal_o, cdbFlags_o, cdbUnit_o, m_tag, m_val, m_fl, m_unit);
                end
            end

            if (!reset_i) begin
                m_rr = 0; m_full = 0; m_tag = '0; m_val = '0; m_fl = '0; m_unit = 0;
            end else if (flush_i) begin
                m_full = 0;
            end else if (ld) begin
                if (w >= 0) begin
                    m_full = 1; m_tag = u_tag[w]; m_val = u_val[w]; m_fl = u_fl[w]; m_unit = w;
                    m_rr = (w + 1) % NU;
                    u_v[w] = 0;
                end else begin
                    m_full = 0;
                end
            end
            next_cycle();
        end
        reset_i = 1'b1; flush_i = 1'b0; unitValid_i = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
